// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default widths for the bypassing register file
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// rtl/regfile_bypass_sb_if.sv - read/write/mark/clear bus between decode, writeback and the register file
interface regfile_bypass_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) ();

    logic                       RegWre;
    logic [ADDR_W-1:0]          WriteReg;
    logic [DATA_W-1:0]          WriteData;
    logic [NUM_RD*ADDR_W-1:0]   ReadReg;
    logic [NUM_RD*DATA_W-1:0]   ReadData;
    logic [NUM_RD-1:0]          ReadBusy;
    logic                       MarkWre;
    logic [ADDR_W-1:0]          MarkReg;
    logic                       ClrReq;
    logic                       ClrBusy;

    modport master (
        output RegWre, WriteReg, WriteData, ReadReg, MarkWre, MarkReg, ClrReq,
        input  ReadData, ReadBusy, ClrBusy
    );

    modport slave (
        input  RegWre, WriteReg, WriteData, ReadReg, MarkWre, MarkReg, ClrReq,
        output ReadData, ReadBusy, ClrBusy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits with set/clear/clear-all and read-port lookups
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     setEn,
    input  logic [ADDR_W-1:0]        setAddr,
    input  logic                     clrEn,
    input  logic [ADDR_W-1:0]        clrAddr,
    input  logic                     clrAll,
    input  logic [NUM_RD*ADDR_W-1:0] lookupAddr,
    output logic [NUM_RD-1:0]        lookupBusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;

    // Set is applied after clear so a mark and a write to the same register leave it pending.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy <= '0;
        end else if (clrAll) begin
            busy <= '0;
        end else begin
            if (clrEn) busy[clrAddr] <= 1'b0;
            if (setEn) busy[setAddr] <= 1'b1;
        end
    end

    always_comb begin
        lookupBusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            lookupBusy[k] = busy[lookupAddr[k*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// rtl/regfile_bypass_sb.sv - multi-read register file with write bypass, pending-write scoreboard and bulk clear
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    regfile_bypass_sb_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_REG = '1;

    state_t                   state;
    logic [ADDR_W-1:0]        sweepCnt;
    logic                     clrBusyQ;
    logic [DATA_W-1:0]        mem [DEPTH];

    logic                     idle;
    logic                     wrEn;
    logic                     markEn;
    logic                     clrAll;
    logic [NUM_RD-1:0]        sbBusy;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdBusy;
    logic [ADDR_W-1:0]        rdAddr;
    logic                     hit;

    assign idle   = (state == IDLE);
    assign wrEn   = idle && bus.RegWre  && (bus.WriteReg != '0);
    assign markEn = idle && bus.MarkWre && (bus.MarkReg  != '0);
    assign clrAll = idle && bus.ClrReq;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .CLK        (CLK),
        .RST        (RST),
        .setEn      (markEn),
        .setAddr    (bus.MarkReg),
        .clrEn      (wrEn),
        .clrAddr    (bus.WriteReg),
        .clrAll     (clrAll),
        .lookupAddr (bus.ReadReg),
        .lookupBusy (sbBusy)
    );

    // A write sampled on the same edge as ClrReq lands first and is then zeroed by the sweep.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state    <= IDLE;
            sweepCnt <= '0;
            clrBusyQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrEn) mem[bus.WriteReg] <= bus.WriteData;
                    if (bus.ClrReq) begin
                        state    <= SWEEP;
                        sweepCnt <= {{(ADDR_W-1){1'b0}}, 1'b1};
                        clrBusyQ <= 1'b1;
                    end
                end
                SWEEP: begin
                    mem[sweepCnt] <= '0;
                    if (sweepCnt == LAST_REG) begin
                        state    <= IDLE;
                        clrBusyQ <= 1'b0;
                    end else begin
                        sweepCnt <= sweepCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdData = '0;
        rdBusy = '0;
        rdAddr = '0;
        hit    = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdAddr = bus.ReadReg[k*ADDR_W +: ADDR_W];
            hit    = (BYPASS != 0) && idle && bus.RegWre && (bus.WriteReg == rdAddr);
            if (rdAddr != '0) begin
                rdData[k*DATA_W +: DATA_W] = hit ? bus.WriteData : mem[rdAddr];
                rdBusy[k]                  = sbBusy[k] & ~hit;
            end
        end
    end

    assign bus.ReadData = rdData;
    assign bus.ReadBusy = rdBusy;
    assign bus.ClrBusy  = clrBusyQ;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb/tb_regfile_bypass_sb.sv - directed self-checking bench for regfile_bypass_sb
module tb_regfile_bypass_sb;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    regfile_bypass_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();
    regfile_bypass_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus1 ();

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut0 (
        .CLK (CLK), .RST (RST), .bus (bus0)
    );

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(0)) dut1 (
        .CLK (CLK), .RST (RST), .bus (bus1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.RegWre = 0; bus0.WriteReg = '0; bus0.WriteData = '0; bus0.ReadReg = '0;
        bus0.MarkWre = 0; bus0.MarkReg = '0; bus0.ClrReq = 0;
        bus1.RegWre = 0; bus1.WriteReg = '0; bus1.WriteData = '0; bus1.ReadReg = '0;
        bus1.MarkWre = 0; bus1.MarkReg = '0; bus1.ClrReq = 0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        bus0.RegWre = 1; bus0.WriteReg = a; bus0.WriteData = d;
        tick();
        bus0.RegWre = 0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        bus1.RegWre = 1; bus1.WriteReg = a; bus1.WriteData = d;
        tick();
        bus1.RegWre = 0;
    endtask

    task automatic test_reset();
        RST = 0;
        bus0.ReadReg = {5'd31, 5'd5};
        #2;
        checks++;
        if (bus0.ReadData !== 64'h0) begin
            errors++; $display("FAIL reset_rdata actual %h required %h", bus0.ReadData, 64'h0);
        end
        checks++;
        if (bus0.ReadBusy !== 2'b00) begin
            errors++; $display("FAIL reset_rbusy actual %b required %b", bus0.ReadBusy, 2'b00);
        end
        checks++;
        if (bus0.ClrBusy !== 1'b0) begin
            errors++; $display("FAIL reset_clrbusy actual %b required 0", bus0.ClrBusy);
        end
        @(negedge CLK);
        RST = 1;
        tick();
        checks++;
        if (bus0.ReadData !== 64'h0) begin
            errors++; $display("FAIL post_reset_rdata actual %h required %h", bus0.ReadData, 64'h0);
        end
    endtask

    task automatic test_write_bypass();
        bus0.ReadReg = {5'd0, 5'd7};
        bus0.RegWre = 1; bus0.WriteReg = 5'd7; bus0.WriteData = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus0.ReadData[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_r7 actual %h required %h", bus0.ReadData[31:0], 32'hDEADBEEF);
        end
        tick();
        bus0.RegWre = 0;
        #1;
        checks++;
        if (bus0.ReadData[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL stored_r7 actual %h required %h", bus0.ReadData[31:0], 32'hDEADBEEF);
        end
        bus0.RegWre = 1; bus0.WriteReg = 5'd0; bus0.WriteData = 32'h1234;
        #1;
        checks++;
        if (bus0.ReadData[63:32] !== 32'h0) begin
            errors++; $display("FAIL r0_bypass actual %h required %h", bus0.ReadData[63:32], 32'h0);
        end
        tick();
        bus0.RegWre = 0;
        #1;
        checks++;
        if (bus0.ReadData[63:32] !== 32'h0) begin
            errors++; $display("FAIL r0_stored actual %h required %h", bus0.ReadData[63:32], 32'h0);
        end
    endtask

    task automatic test_scoreboard();
        bus0.ReadReg = {5'd0, 5'd3};
        bus0.MarkWre = 1; bus0.MarkReg = 5'd3;
        tick();
        bus0.MarkWre = 0;
        #1;
        checks++;
        if (bus0.ReadBusy[0] !== 1'b1) begin
            errors++; $display("FAIL mark_r3 actual %b required 1", bus0.ReadBusy[0]);
        end
        bus0.RegWre = 1; bus0.WriteReg = 5'd3; bus0.WriteData = 32'h12;
        #1;
        checks++;
        if (bus0.ReadBusy[0] !== 1'b0) begin
            errors++; $display("FAIL busy_bypass_r3 actual %b required 0", bus0.ReadBusy[0]);
        end
        tick();
        bus0.RegWre = 0;
        #1;
        checks++;
        if (bus0.ReadBusy[0] !== 1'b0 || bus0.ReadData[31:0] !== 32'h12) begin
            errors++; $display("FAIL busy_cleared_r3 actual %b/%h required 0/%h",
                               bus0.ReadBusy[0], bus0.ReadData[31:0], 32'h12);
        end
        bus0.MarkWre = 1; bus0.MarkReg = 5'd3;
        bus0.RegWre = 1; bus0.WriteReg = 5'd3; bus0.WriteData = 32'h34;
        tick();
        bus0.MarkWre = 0; bus0.RegWre = 0;
        #1;
        checks++;
        if (bus0.ReadBusy[0] !== 1'b1 || bus0.ReadData[31:0] !== 32'h34) begin
            errors++; $display("FAIL mark_wins_r3 actual %b/%h required 1/%h",
                               bus0.ReadBusy[0], bus0.ReadData[31:0], 32'h34);
        end
    endtask

    task automatic test_sweep();
        int count;
        for (int i = 1; i < 32; i++) wr0(5'(i), 32'(i));
        bus0.ReadReg = {5'd31, 5'd17};
        #1;
        checks++;
        if (bus0.ReadData !== {32'd31, 32'd17}) begin
            errors++; $display("FAIL fill_readback actual %h required %h", bus0.ReadData, {32'd31, 32'd17});
        end
        bus0.ClrReq = 1;
        tick();
        bus0.ClrReq = 0;
        checks++;
        if (bus0.ClrBusy !== 1'b1) begin
            errors++; $display("FAIL clrbusy_rise actual %b required 1", bus0.ClrBusy);
        end
        bus0.RegWre = 1; bus0.WriteReg = 5'd31; bus0.WriteData = 32'hFFFFFFFF;
        bus0.MarkWre = 1; bus0.MarkReg = 5'd4;
        bus0.ReadReg = {5'd4, 5'd31};
        #1;
        checks++;
        if (bus0.ReadData[31:0] !== 32'd31) begin
            errors++; $display("FAIL sweep_no_bypass actual %h required %h", bus0.ReadData[31:0], 32'd31);
        end
        count = 0;
        while (bus0.ClrBusy === 1'b1 && count < 100) begin
            count++;
            tick();
        end
        idle_inputs();
        checks++;
        if (count != 31) begin
            errors++; $display("FAIL clrbusy_cycles actual %0d required 31", count);
        end
        for (int a = 0; a < 32; a++) begin
            bus0.ReadReg = {5'd0, 5'(a)};
            #1;
            checks++;
            if (bus0.ReadData[31:0] !== 32'h0 || bus0.ReadBusy[0] !== 1'b0) begin
                errors++; $display("FAIL swept_r%0d actual %h/%b required 0/0", a,
                                   bus0.ReadData[31:0], bus0.ReadBusy[0]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        wr0(5'd20, 32'h20);
        wr0(5'd30, 32'h30);
        bus0.ClrReq = 1;
        tick();
        bus0.ClrReq = 0;
        repeat (9) tick();
        checks++;
        if (bus0.ClrBusy !== 1'b1) begin
            errors++; $display("FAIL mid_sweep_busy actual %b required 1", bus0.ClrBusy);
        end
        bus0.ReadReg = {5'd30, 5'd20};
        RST = 0;
        #1;
        checks++;
        if (bus0.ClrBusy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_clrbusy actual %b required 0", bus0.ClrBusy);
        end
        checks++;
        if (bus0.ReadData !== 64'h0) begin
            errors++; $display("FAIL rst_mid_rdata actual %h required %h", bus0.ReadData, 64'h0);
        end
        #2;
        RST = 1;
        tick();
        wr0(5'd12, 32'hABCD);
        bus0.ReadReg = {5'd0, 5'd12};
        #1;
        checks++;
        if (bus0.ReadData[31:0] !== 32'hABCD) begin
            errors++; $display("FAIL write_after_rst actual %h required %h", bus0.ReadData[31:0], 32'hABCD);
        end
    endtask

    task automatic test_no_bypass();
        bus1.ReadReg = {4{5'd2}};
        wr1(5'd2, 32'h11);
        bus1.RegWre = 1; bus1.WriteReg = 5'd2; bus1.WriteData = 32'h55;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus1.ReadData[k*32 +: 32] !== 32'h11) begin
                errors++; $display("FAIL nobyp_old_p%0d actual %h required %h", k, bus1.ReadData[k*32 +: 32], 32'h11);
            end
        end
        tick();
        bus1.RegWre = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus1.ReadData[k*32 +: 32] !== 32'h55) begin
                errors++; $display("FAIL nobyp_new_p%0d actual %h required %h", k, bus1.ReadData[k*32 +: 32], 32'h55);
            end
        end
        bus1.MarkWre = 1; bus1.MarkReg = 5'd2;
        tick();
        bus1.MarkWre = 0;
        bus1.RegWre = 1; bus1.WriteReg = 5'd2; bus1.WriteData = 32'h66;
        #1;
        checks++;
        if (bus1.ReadBusy !== 4'hF) begin
            errors++; $display("FAIL nobyp_raw_busy actual %b required %b", bus1.ReadBusy, 4'hF);
        end
        tick();
        bus1.RegWre = 0;
        #1;
        checks++;
        if (bus1.ReadBusy !== 4'h0) begin
            errors++; $display("FAIL nobyp_busy_cleared actual %b required %b", bus1.ReadBusy, 4'h0);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_bypass();
        test_scoreboard();
        test_sweep();
        test_reset_mid_sweep();
        test_no_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1);
    end

endmodule
